// File: rtl/cpu_port_pins.sv
`default_nettype none
// ============================================================================
// Module      : cpu_port_pins
// Description : Resolves the effective level of the eight 6510 CPU port pins
//               from the DDR/data registers, external pull-ups, the cassette
//               sense input and the charge fade of the two floating pins.
//               Drives the C64 banking lines and the cassette motor/write
//               lines. pins_o is the read-back source for $01 reads.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1  system clock
//   reset_n        in   1  asynchronous active-low reset
//   cpuport_ddr    in   8  port direction register, 1 = output
//   cpuport_value  in   8  port data register
//   tape_sense_i   in   1  cassette button sense (async), 0 = pressed
//   pins_o         out  8  registered effective pin levels
//   lo_ram         out  1  LORAM  (pins_o[0])
//   hi_ram         out  1  HIRAM  (pins_o[1])
//   charen         out  1  CHAREN (pins_o[2])
//   tape_write_o   out  1  cassette write line (pins_o[3])
//   tape_motor_o   out  1  1 = motor on (bit 5 driven low)
//   bank_changed   out  1  one-cycle pulse when {charen,hi_ram,lo_ram} moves
// ============================================================================
module cpu_port_pins #(
  parameter int                FADE_W      = 24,
  // Must be >= 2: the terminal count is FADE_CYCLES-1 and must be reachable
  // after at least one increment.
  parameter logic [FADE_W-1:0] FADE_CYCLES = 24'd14_000_000,
  parameter logic [7:0]        PULLUP_MASK = 8'h2F,
  parameter logic [7:0]        FLOAT_MASK  = 8'hC0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] cpuport_ddr,
  input  logic [7:0] cpuport_value,
  input  logic       tape_sense_i,
  output logic [7:0] pins_o,
  output logic       lo_ram,
  output logic       hi_ram,
  output logic       charen,
  output logic       tape_write_o,
  output logic       tape_motor_o,
  output logic       bank_changed
);

  localparam logic [7:0]        PINS_RESET = 8'h37;
  localparam logic [FADE_W-1:0] FADE_LAST  =
    FADE_CYCLES - {{(FADE_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Cassette sense synchroniser. Resets to 1 (button released) so a reset
  // never shows a spurious press on bit 4.
  // --------------------------------------------------------------------------
  logic sense_meta;
  logic sense_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sense_meta <= 1'b1;
      sense_s    <= 1'b1;
    end else begin
      sense_meta <= tape_sense_i;
      sense_s    <= sense_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Floating-pin charge model. A floating bit keeps the last level it was
  // driven with; a stored 1 leaks away after FADE_CYCLES undriven clocks.
  //   HELD   : ddr=1, charge follows value, counter parked at 0
  //   FADING : ddr=0, charge=1, counter running
  //   EMPTY  : ddr=0, charge=0, counter parked at 0
  // The counter is cleared on terminal count so it can never wrap.
  // --------------------------------------------------------------------------
  logic [7:0] charge;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    if (FLOAT_MASK[i]) begin : g_float
      logic              chg;
      logic [FADE_W-1:0] cnt;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          chg <= 1'b0;
          cnt <= '0;
        end else if (cpuport_ddr[i]) begin
          // Driving the pin (re)charges it; any fade in progress is abandoned.
          chg <= cpuport_value[i];
          cnt <= '0;
        end else if (chg) begin
          if (cnt == FADE_LAST) begin
            chg <= 1'b0;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end

      assign charge[i] = chg;
    end else begin : g_fixed
      assign charge[i] = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Next pin level. An output bit always wins; an input bit takes its source
  // from the board: tape sense on bit 4, stored charge on floating bits,
  // pull-up (or nothing) elsewhere. Computed only from the current ddr/value
  // pair, so a simultaneous change of both never exposes a mixed state.
  // --------------------------------------------------------------------------
  logic [7:0] pins_next;

  always_comb begin
    pins_next = '0;
    for (int i = 0; i < 8; i++) begin
      if (cpuport_ddr[i]) begin
        pins_next[i] = cpuport_value[i];
      end else if (i == 4) begin
        pins_next[i] = sense_s;
      end else if (FLOAT_MASK[i]) begin
        pins_next[i] = charge[i];
      end else begin
        pins_next[i] = PULLUP_MASK[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output registers. bank_changed compares the incoming banking bits with
  // those currently presented, so it rises together with the new levels.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pins_o       <= PINS_RESET;
      tape_motor_o <= 1'b0;
      bank_changed <= 1'b0;
    end else begin
      pins_o       <= pins_next;
      tape_motor_o <= cpuport_ddr[5] & ~cpuport_value[5];
      bank_changed <= (pins_next[2:0] != pins_o[2:0]);
    end
  end

  assign lo_ram       = pins_o[0];
  assign hi_ram       = pins_o[1];
  assign charen       = pins_o[2];
  assign tape_write_o = pins_o[3];

endmodule
`default_nettype wire

// File: tb/tb_cpu_port_pins.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_port_pins
// Description : Self-checking bench for cpu_port_pins (fade length 8 clks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_port_pins;

  localparam int         F     = 8;
  localparam logic [7:0] PULL  = 8'h2F;
  localparam logic [7:0] FLOAT = 8'hC0;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] ddr = 8'h00;
  logic [7:0] val = 8'h00;
  logic       sense = 1'b1;

  logic [7:0] pins;
  logic       lo, hi, chr, wr, mot, bc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu_port_pins #(
    .FADE_W     (24),
    .FADE_CYCLES(24'd8),
    .PULLUP_MASK(8'h2F),
    .FLOAT_MASK (8'hC0)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cpuport_ddr  (ddr),
    .cpuport_value(val),
    .tape_sense_i (sense),
    .pins_o       (pins),
    .lo_ram       (lo),
    .hi_ram       (hi),
    .charen       (chr),
    .tape_write_o (wr),
    .tape_motor_o (mot),
    .bank_changed (bc)
  );

  // --------------------------------------------------------------------------
  // Reference model: each floating pin remembers the level it was last driven
  // with and how many undriven samples it has seen; it reads that level while
  // fewer than F samples have elapsed. Tape sense is seen two samples late.
  // --------------------------------------------------------------------------
  logic [7:0] m_pins;
  logic       m_motor;
  logic       m_bank;
  logic       m_held [8];
  int         m_age  [8];
  logic       m_h1, m_h2;

  task automatic model_reset();
    m_pins  = 8'h37;
    m_motor = 1'b0;
    m_bank  = 1'b0;
    m_h1    = 1'b1;
    m_h2    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      m_held[i] = 1'b0;
      m_age[i]  = 0;
    end
  endtask

  task automatic model_edge();
    logic [7:0] nxt;
    if (!reset_n) begin
      model_reset();
      return;
    end
    nxt = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (ddr[i])        nxt[i] = val[i];
      else if (i == 4)   nxt[i] = m_h2;
      else if (FLOAT[i]) nxt[i] = m_held[i] && (m_age[i] < F);
      else               nxt[i] = PULL[i];
    end
    for (int i = 0; i < 8; i++) begin
      if (FLOAT[i]) begin
        if (ddr[i]) begin
          m_held[i] = val[i];
          m_age[i]  = 0;
        end else if (m_age[i] < F) begin
          m_age[i] = m_age[i] + 1;
        end
      end
    end
    m_h2    = m_h1;
    m_h1    = sense;
    m_bank  = (nxt[2:0] != m_pins[2:0]);
    m_pins  = nxt;
    m_motor = ddr[5] & ~val[5];
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_pins"}, {8'h00, pins}, {8'h00, m_pins});
    chk({tag, "_outs"}, {10'h000, mot, wr, bc, chr, hi, lo},
        {10'h000, m_motor, m_pins[3], m_bank, m_pins[2:0]});
  endtask

  typedef struct {
    logic [7:0] ddr;
    logic [7:0] val;
    logic [7:0] pins;
    logic       motor;
    logic       bank;
  } vec_t;

  vec_t tbl [11];

  initial begin
    // Sequence applied straight after reset with tape sense idle (1).
    tbl[0]  = '{8'h00, 8'h00, 8'h3F, 1'b0, 1'b0};
    tbl[1]  = '{8'hFF, 8'h35, 8'h35, 1'b0, 1'b1};
    tbl[2]  = '{8'hFF, 8'h35, 8'h35, 1'b0, 1'b0};
    tbl[3]  = '{8'h00, 8'h00, 8'h3F, 1'b0, 1'b1};
    tbl[4]  = '{8'h2F, 8'h0F, 8'h1F, 1'b1, 1'b0};
    tbl[5]  = '{8'h2F, 8'h2F, 8'h3F, 1'b0, 1'b0};
    tbl[6]  = '{8'hFF, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[7]  = '{8'h07, 8'h02, 8'h3A, 1'b0, 1'b1};
    tbl[8]  = '{8'hC0, 8'hC0, 8'hFF, 1'b0, 1'b1};
    tbl[9]  = '{8'h00, 8'h00, 8'hFF, 1'b0, 1'b0};
    tbl[10] = '{8'hFF, 8'h35, 8'h35, 1'b0, 1'b1};

    // ---- asynchronous reset, checked before any clock edge ----
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_pins", {8'h00, pins}, 16'h0037);
    chk("rst_outs", {10'h000, mot, wr, bc, chr, hi, lo}, 16'h0007);
    repeat (2) tick();
    reset_n = 1'b1;

    // ---- table-driven vectors ----
    for (int r = 0; r < 11; r++) begin
      ddr = tbl[r].ddr;
      val = tbl[r].val;
      tick();
      chk($sformatf("tbl%0d_pins", r), {8'h00, pins}, {8'h00, tbl[r].pins});
      chk($sformatf("tbl%0d_motor", r), {15'h0, mot}, {15'h0, tbl[r].motor});
      chk($sformatf("tbl%0d_bank", r), {15'h0, bc}, {15'h0, tbl[r].bank});
      chk($sformatf("tbl%0d_lines", r), {12'h000, wr, chr, hi, lo},
          {12'h000, tbl[r].pins[3:0]});
    end

    // ---- fade: charged 1s hold for exactly F clocks after release ----
    ddr = 8'hFF; val = 8'hC0;
    tick();
    chk("fadeA_load", {8'h00, pins}, 16'h00C0);
    ddr = 8'h3F;
    for (int k = 1; k <= F + 2; k++) begin
      tick();
      chk($sformatf("fadeA_k%0d", k), {8'h00, pins}, (k <= F) ? 16'h00C0 : 16'h0000);
    end

    // ---- fade restart: DDR re-asserted mid-fade ----
    ddr = 8'hFF; val = 8'hC0;
    tick();
    ddr = 8'h3F;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("fadeB_pre%0d", k), {8'h00, pins}, 16'h00C0);
    end
    ddr = 8'hFF;
    tick();
    chk("fadeB_pulse", {8'h00, pins}, 16'h00C0);
    ddr = 8'h3F;
    for (int k = 1; k <= F + 2; k++) begin
      tick();
      chk($sformatf("fadeB_k%0d", k), {8'h00, pins}, (k <= F) ? 16'h00C0 : 16'h0000);
    end

    // ---- tape sense latency, then driven bit 4 overrides sense ----
    ddr = 8'h00; val = 8'h00;
    repeat (3) tick();
    sense = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("sense_k%0d", k), {15'h0, pins[4]}, (k < 3) ? 16'h0001 : 16'h0000);
    end
    ddr = 8'h10; val = 8'h10;
    tick();
    chk("sense_drv", {15'h0, pins[4]}, 16'h0001);
    sense = 1'b1;

    // ---- reset mid-run, then first clock after release ----
    ddr = 8'hFF; val = 8'h00;
    tick();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst2_pins", {8'h00, pins}, 16'h0037);
    chk("rst2_outs", {10'h000, mot, wr, bc, chr, hi, lo}, 16'h0007);
    ddr = 8'h00; val = 8'h00;
    tick();
    reset_n = 1'b1;
    tick();
    chk("rel_pins", {8'h00, pins}, 16'h003F);
    chk("rel_bank", {15'h0, bc}, 16'h0000);

    // ---- randomized run against the reference model ----
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) ddr = 8'($urandom);
      if ($urandom_range(0, 1) == 0) val = 8'($urandom);
      if ($urandom_range(0, 3) == 0) sense = ~sense;
      tick();
      chk_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
